param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo_if.sv | 34 +++
 rtl/param_sync_fifo.sv | 115 +++++++++++
 tb/tb_param_sync_fifo.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/param_sync_fifo_if.sv
// Handshake/status bundle for param_sync_fifo.
// The producer/consumer side drives the master modport, and the FIFO uses the slave modport.
interface param_sync_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             i_wr_en;
  logic [WIDTH-1:0] i_wr_data;
  logic             i_rd_en;
  logic             i_clr_err;
  logic [WIDTH-1:0] o_rd_data;
  logic             o_rd_valid;
  logic             o_empty;
  logic             o_full;
  logic             o_almost_full;
  logic             o_almost_empty;
  logic [CW-1:0]    o_count;
  logic             o_overflow;
  logic             o_underflow;

  modport master (
    output i_wr_en, i_wr_data, i_rd_en, i_clr_err,
    input  o_rd_data, o_rd_valid, o_empty, o_full, o_almost_full,
           o_almost_empty, o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_wr_en, i_wr_data, i_rd_en, i_clr_err,
    output o_rd_data, o_rd_valid, o_empty, o_full, o_almost_full,
           o_almost_empty, o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, occupancy flags and sticky error flags.
// Reads are either registered or first-word-fall-through, selected by FWFT.
module param_sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  param_sync_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             empty_s, full_s, wr_acc_s, rd_acc_s;
  logic [WIDTH-1:0] head_s;

  assign empty_s  = (count_q == CNT_ZERO);
  assign full_s   = (count_q == CNT_FULL);
  assign wr_acc_s = bus.i_wr_en & ~full_s;
  assign rd_acc_s = bus.i_rd_en & ~empty_s;
  assign head_s   = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state logic: acceptance uses the flags as they stood before the edge.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_acc_s) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      rd_data_d  = head_s;
      rd_valid_d = 1'b1;
    end else begin
      rd_ptr_d   = rd_ptr_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
    end
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // A fresh error on the clearing edge wins over the clear.
    ovf_d = (bus.i_wr_en & full_s)  | (ovf_q & ~bus.i_clr_err);
    unf_d = (bus.i_rd_en & empty_s) | (unf_q & ~bus.i_clr_err);
  end

  // Control and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q   <= {(AW+1){1'b0}};
      rd_ptr_q   <= {(AW+1){1'b0}};
      count_q    <= CNT_ZERO;
      rd_data_q  <= {WIDTH{1'b0}};
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Storage array; deliberately not cleared by reset.
  always_ff @(posedge i_clk) begin
    if (wr_acc_s && !i_rst) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.i_wr_data;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Masked while empty so nothing stale shows after a reset.
      assign bus.o_rd_data  = empty_s ? {WIDTH{1'b0}} : head_s;
      assign bus.o_rd_valid = ~empty_s;
    end else begin : g_reg
      assign bus.o_rd_data  = rd_data_q;
      assign bus.o_rd_valid = rd_valid_q;
    end
  endgenerate

  assign bus.o_empty        = empty_s;
  assign bus.o_full         = full_s;
  assign bus.o_almost_full  = (count_q >= AF_C);
  assign bus.o_almost_empty = (count_q <= AE_C);
  assign bus.o_count        = count_q;
  assign bus.o_overflow     = ovf_q;
  assign bus.o_underflow    = unf_q;
endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: a registered-read instance checked against a queue model
// and a scoreboard, plus a first-word-fall-through instance.
module tb_param_sync_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;

  logic [7:0] fifo_m [$];
  logic [7:0] sb_q [$];
  logic [7:0] last_m = 8'h00;
  logic       valid_m = 1'b0;
  logic       ovf_m = 1'b0;
  logic       unf_m = 1'b0;

  always #5 clk = ~clk;

  param_sync_fifo_if #(.WIDTH(8), .DEPTH(16)) bus0 ();
  param_sync_fifo_if #(.WIDTH(8), .DEPTH(16)) bus1 ();

  param_sync_fifo #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus0.slave)
  );

  param_sync_fifo #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus1.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int c;
    c = fifo_m.size();
    if (valid_m) begin
      last_m = sb_q.pop_front();
    end
    chk({tag, " count"},    32'(bus0.o_count), 32'(c));
    chk({tag, " empty"},    32'(bus0.o_empty), 32'(c == 0));
    chk({tag, " full"},     32'(bus0.o_full), 32'(c == 16));
    chk({tag, " afull"},    32'(bus0.o_almost_full), 32'(c >= 14));
    chk({tag, " aempty"},   32'(bus0.o_almost_empty), 32'(c <= 2));
    chk({tag, " overflow"}, 32'(bus0.o_overflow), 32'(ovf_m));
    chk({tag, " underflow"}, 32'(bus0.o_underflow), 32'(unf_m));
    chk({tag, " rd_valid"}, 32'(bus0.o_rd_valid), 32'(valid_m));
    chk({tag, " rd_data"},  32'(bus0.o_rd_data), 32'(last_m));
  endtask

  task automatic step(input string tag, input logic wr, input logic [7:0] d,
                      input logic rd, input logic clr);
    logic full_m, empty_m, wa, ra;
    full_m  = (fifo_m.size() == 16);
    empty_m = (fifo_m.size() == 0);
    wa = wr && !full_m;
    ra = rd && !empty_m;
    if (ra) sb_q.push_back(fifo_m.pop_front());
    if (wa) fifo_m.push_back(d);
    ovf_m   = (wr && full_m) || (ovf_m && !clr);
    unf_m   = (rd && empty_m) || (unf_m && !clr);
    valid_m = ra;
    bus0.i_wr_en   = wr;
    bus0.i_wr_data = d;
    bus0.i_rd_en   = rd;
    bus0.i_clr_err = clr;
    @(posedge clk);
    #1;
    bus0.i_wr_en   = 1'b0;
    bus0.i_rd_en   = 1'b0;
    bus0.i_clr_err = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus0.i_wr_en   = 1'b1;
    bus0.i_wr_data = 8'hFF;
    bus0.i_rd_en   = 1'b1;
    fifo_m.delete();
    sb_q.delete();
    last_m = 8'h00; valid_m = 1'b0; ovf_m = 1'b0; unf_m = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus0.i_wr_en = 1'b0;
    bus0.i_rd_en = 1'b0;
    check_all(tag);
  endtask

  initial begin
    bus0.i_wr_en = 1'b0; bus0.i_wr_data = 8'h00; bus0.i_rd_en = 1'b0; bus0.i_clr_err = 1'b0;
    bus1.i_wr_en = 1'b0; bus1.i_wr_data = 8'h00; bus1.i_rd_en = 1'b0; bus1.i_clr_err = 1'b0;
    @(posedge clk);
    do_reset("reset");

    // Fill 0x01..0x10, then overflow and clear-vs-new-error priority.
    for (int i = 1; i <= 16; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    step("overflow", 1'b1, 8'h99, 1'b0, 1'b0);
    step("ovf_clr_same_edge", 1'b1, 8'h98, 1'b0, 1'b1);
    step("ovf_clear", 1'b0, 8'h00, 1'b0, 1'b1);

    // Drain in order, then underflow.
    for (int i = 0; i < 16; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    step("underflow", 1'b0, 8'h00, 1'b1, 1'b0);
    step("unf_clear", 1'b0, 8'h00, 1'b0, 1'b1);

    // Empty with both requests: write wins, underflow flagged.
    step("empty_both", 1'b1, 8'h77, 1'b1, 1'b0);
    step("clr", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step("refill", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    // Full with both requests: read wins, write lost.
    step("full_both", 1'b1, 8'hEE, 1'b1, 1'b0);
    step("clr2", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step("to8", 1'b0, 8'h00, 1'b1, 1'b0);

    // Steady occupancy 8 with pointer wrap.
    for (int i = 0; i < 40; i++) step("rw_wrap", 1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);

    // Mid-operation reset discards contents.
    for (int i = 0; i < 3; i++) step("to5", 1'b0, 8'h00, 1'b1, 1'b0);
    do_reset("mid_reset");
    step("post_rst_wr", 1'b1, 8'h3C, 1'b0, 1'b0);
    step("post_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    step("post_rst_idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // First-word-fall-through instance.
    chk("fwft_rst_valid", 32'(bus1.o_rd_valid), 32'd0);
    chk("fwft_rst_data", 32'(bus1.o_rd_data), 32'd0);
    bus1.i_wr_en = 1'b1; bus1.i_wr_data = 8'hA5;
    @(posedge clk); #1;
    bus1.i_wr_en = 1'b0;
    chk("fwft_a5_data", 32'(bus1.o_rd_data), 32'hA5);
    chk("fwft_a5_valid", 32'(bus1.o_rd_valid), 32'd1);
    @(posedge clk); #1;
    chk("fwft_hold_data", 32'(bus1.o_rd_data), 32'hA5);
    bus1.i_rd_en = 1'b1;
    @(posedge clk); #1;
    bus1.i_rd_en = 1'b0;
    chk("fwft_pop_empty", 32'(bus1.o_empty), 32'd1);
    chk("fwft_pop_valid", 32'(bus1.o_rd_valid), 32'd0);
    bus1.i_wr_en = 1'b1; bus1.i_wr_data = 8'h5A;
    @(posedge clk); #1;
    bus1.i_wr_data = 8'hC3;
    @(posedge clk); #1;
    bus1.i_wr_en = 1'b0;
    chk("fwft_head1", 32'(bus1.o_rd_data), 32'h5A);
    chk("fwft_count2", 32'(bus1.o_count), 32'd2);
    bus1.i_rd_en = 1'b1;
    @(posedge clk); #1;
    bus1.i_rd_en = 1'b0;
    chk("fwft_head2", 32'(bus1.o_rd_data), 32'hC3);
    chk("fwft_valid2", 32'(bus1.o_rd_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
